intr_timer_gen: RTL and testbench
=================================

# intr_timer_gen

Programmable countdown timer that drives a level interrupt line toward the core's interrupt synchronizer. The interrupt is held high until software clears it through a register write. After each clear, the line is held low for a guaranteed minimum time, so that the synchronizer's rising-edge detector sees every distinct interrupt. The block sits on the peripheral side, and its `intr` output connects directly to the synchronizer's asynchronous `intr` input.

## Interface
- `CNT_W`, default 32: counter and register data width (≥ 2).
- `MIN_LOW`, default 3: minimum number of cycles `intr` stays low after a clear (≥ 1). Set it to at least the synchronizer's `SYNC_STAGES` + 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wr_en`  in  1  register write strobe, one write per cycle.
- `wr_addr`  in  2  write address: 0 = CTRL, 1 = LOAD, 2 = CLR, 3 = read-only (writes ignored).
- `wr_data`  in  `CNT_W`  write data.
- `rd_addr`  in  2  read address, same map.
- `rd_data`  out  `CNT_W`  combinational read data. CTRL = {0…, PERIODIC, EN}; LOAD; CLR reads {0…, pending, intr}; 3 = current counter value.
- `intr`  out  1  registered interrupt level.

## Operation
Registers:
- **CTRL**
  - bit0 = EN, bit1 = PERIODIC.
  - A write with EN = 1 while EN was 0 also loads counter ← LOAD.
  - A write with EN = 0 freezes the counter at its current value.
- **LOAD**
  - A write updates LOAD.
  - If EN = 1, the counter is also reloaded with the new value on the same edge.
- **CLR**
  - A write with `wr_data[0]` = 1 is a clear request. Other bits are ignored.

Counter:
- When EN = 1 and counter ≠ 0, the counter decrements by 1 per cycle.
- `expire` = EN & (counter == 0), combinational.
- On an expire cycle:
  - PERIODIC = 1: counter ← LOAD.
  - PERIODIC = 0: counter stays 0 and EN ← 0 (one-shot).
- A CTRL or LOAD write in the same cycle as expire takes priority for the counter and EN. The expire event itself is still delivered.
- LOAD = 0 with PERIODIC = 1 expires every cycle; this is legal.

Interrupt FSM states: IDLE (`intr` = 0), ASSERT (`intr` = 1), HOLDOFF (`intr` = 0, low-timer running). A `pending` flag records one coalesced event.
- IDLE:
  - expire → ASSERT.
  - clear → no effect.
- ASSERT:
  - expire alone → stay in ASSERT. The event is absorbed, not counted.
  - clear → HOLDOFF, low-timer ← `MIN_LOW`.
  - clear and expire in the same cycle → HOLDOFF with `pending` = 1.
- HOLDOFF:
  - expire → `pending` = 1. Multiple expiries collapse into a single pending event.
  - clear → `pending` = 0.
  - When the low-timer reaches its end: `pending` = 1 → ASSERT and `pending` ← 0; otherwise → IDLE.
- Reset, including mid-operation:
  - CTRL = 0, LOAD = 0, counter = 0, `pending` = 0, state = IDLE, `intr` = 0, `rd_data` reflects the zeros.
  - No interrupt is generated until software re-enables the timer.

## Timing
- Start-to-expire:
  - A write of LOAD = N with EN = 1 (or an EN 0→1 write) is sampled at edge 0; the counter holds N after edge 0.
  - The counter reaches 0 after edge N, so expire is high in the cycle after edge N.
  - `intr` = 1 after edge N+1. Latency from the enabling write to `intr` is N+1 edges.
- Periodic period: LOAD+1 cycles between consecutive expire cycles.
- Clear:
  - A clear sampled at edge c gives `intr` = 0 after edge c.
  - `intr` stays 0 for exactly `MIN_LOW` cycles.
  - With `pending` set, `intr` = 1 again after edge c+`MIN_LOW`.
- `intr` never pulses low for fewer than `MIN_LOW` cycles and never glitches, because it comes straight from a flop.
- `rd_data` has zero-cycle latency and shows post-edge register state.

## Test plan
- **One-shot:** LOAD = 5, then CTRL = 1 at edge 0 → `intr` rises after edge 6, stays high; EN reads 0 and counter reads 0 afterward.
- **Periodic with clear:** LOAD = 3, CTRL = 3 → expires every 4 cycles. Clearing within 1 cycle of each rise → `intr` low for exactly `MIN_LOW` = 3 cycles. Each rise is seen as one `intr_pulse` by the synchronizer with `SYNC_STAGES` = 2.
- **Holdoff coalescing:** LOAD = 0, PERIODIC = 1, clear issued → `intr` low for exactly 3 cycles, then high again; `pending` reads 1 during holdoff.
- **Simultaneous clear and expire in ASSERT:** `pending` = 1; `intr` is low 3 cycles and then re-asserts.
- **Write priority:** LOAD written to 10 in the same cycle as expire (periodic) → counter = 10 next cycle, and `intr` still asserts from that expire.
- **Reset mid-operation:** `rst_n` driven low asynchronously while `intr` = 1 and counter = 7 → `intr`, counter and CTRL are 0 immediately; after release, no `intr` for 100 cycles.

Source files
------------

// File: rtl/intr_timer_gen.sv
// rtl/intr_timer_gen.sv - countdown timer with level interrupt and guaranteed post-clear low time
module intr_timer_gen #(
    parameter int CNT_W   = 32,
    parameter int MIN_LOW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [1:0]       rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             intr
);

    localparam int LOW_W = $clog2(MIN_LOW + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic               periodic_q, periodic_d;
    logic [CNT_W-1:0]   load_q, load_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic [LOW_W-1:0]   low_q, low_d;
    logic               intr_q, intr_d;

    logic ctrl_wr, load_wr, clr, expire, pend_eff;

    assign ctrl_wr = wr_en && (wr_addr == 2'd0);
    assign load_wr = wr_en && (wr_addr == 2'd1);
    assign clr     = wr_en && (wr_addr == 2'd2) && wr_data[0];
    assign expire  = en_q && (cnt_q == '0);

    // Counter and enable: normal countdown/expiry first, register writes override.
    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        load_d     = load_q;
        cnt_d      = cnt_q;
        if (expire) begin
            if (periodic_q) cnt_d = load_q;
            else            en_d  = 1'b0;
        end else if (en_q) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (ctrl_wr) begin
            en_d       = wr_data[0];
            periodic_d = wr_data[1];
            if (!wr_data[0])    cnt_d = cnt_q;
            else if (!en_q)     cnt_d = load_q;
        end
        if (load_wr) begin
            load_d = wr_data;
            en_d   = en_q;
            if (en_q) cnt_d = wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        low_d     = low_q;
        pend_eff  = (pending_q && !clr) || expire;
        case (state_q)
            S_IDLE: begin
                if (expire) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                if (clr) begin
                    state_d   = S_HOLDOFF;
                    low_d     = LOW_W'(MIN_LOW);
                    pending_d = expire;
                end
            end
            S_HOLDOFF: begin
                // Last low cycle: a coalesced event re-raises the line on this edge.
                if (low_q <= LOW_W'(1)) begin
                    pending_d = 1'b0;
                    state_d   = pend_eff ? S_ASSERT : S_IDLE;
                end else begin
                    low_d     = low_q - LOW_W'(1);
                    pending_d = pend_eff;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
        endcase
        intr_d = (state_d == S_ASSERT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            load_q     <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            low_q      <= '0;
            intr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            periodic_q <= periodic_d;
            load_q     <= load_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            low_q      <= low_d;
            intr_q     <= intr_d;
        end
    end

    assign intr = intr_q;

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            2'd0:    rd_data[1:0] = {periodic_q, en_q};
            2'd1:    rd_data      = load_q;
            2'd2:    rd_data[1:0] = {pending_q, intr_q};
            default: rd_data      = cnt_q;
        endcase
    end

endmodule

// File: tb/tb_intr_timer_gen.sv
// tb/tb_intr_timer_gen.sv - directed table and sequence bench for intr_timer_gen
module tb_intr_timer_gen;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        intr;

    int n_cmp = 0;
    int n_bad = 0;

    intr_timer_gen #(.CNT_W(32), .MIN_LOW(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .intr    (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage synchronizer plus rising-edge detector on the core side.
    logic s1, s2, s3;
    int   pulses;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; pulses <= 0;
        end else begin
            s1 <= intr; s2 <= s1; s3 <= s2;
            if (s2 && !s3) pulses <= pulses + 1;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_intr;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0; wr_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_intr(output int n);
        n = 0;
        while (!intr && n < 50) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int lowcnt;
        int hi;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) step();
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk($sformatf("reset_rd%0d", a), rd_data, 32'd0);
        end
        chk("reset_intr", {31'd0, intr}, 32'd0);
        rst_n = 1'b1;
        step();

        // One-shot LOAD=5: rise after edge 6, then clear and holdoff into IDLE.
        tbl[0]  = '{1'b1, 2'd1, 32'd5, 2'd1, 32'd5, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 32'd1, 2'd3, 32'd5, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd4, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd3, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd2, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd1, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 32'd0, 2'd3, 32'd0, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 32'd0, 2'd0, 32'd0, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b1};
        tbl[10] = '{1'b1, 2'd2, 32'd1, 2'd2, 32'd0, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};
        tbl[14] = '{1'b1, 2'd2, 32'd1, 2'd2, 32'd0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; rd_addr = tbl[i].ra;
            step();
            wr_en = 1'b0;
            chk($sformatf("vec%0d_rd", i), rd_data, tbl[i].exp_rd);
            chk($sformatf("vec%0d_intr", i), {31'd0, intr}, {31'd0, tbl[i].exp_intr});
        end

        // Periodic LOAD=3 with prompt clears: 3-cycle lows, one sync pulse per rise.
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd3);
        wait_intr(n);
        chk("periodic_latency", n, 32'd4);
        for (int k = 0; k < 3; k++) begin
            wr(2'd2, 32'd1);
            lowcnt = 0;
            while (!intr && lowcnt < 20) begin
                lowcnt++;
                step();
            end
            chk($sformatf("periodic_low%0d", k), lowcnt, 32'd3);
        end
        wr(2'd0, 32'd0);
        wr(2'd2, 32'd1);
        repeat (10) step();
        chk("sync_pulses", pulses, 32'd4);
        chk("periodic_idle_intr", {31'd0, intr}, 32'd0);

        // Coalescing with LOAD=0 periodic: pending reads 1 through the holdoff.
        do_reset();
        rd_addr = 2'd2;
        wr(2'd0, 32'd3);
        step();
        chk("coal_rise", rd_data, 32'd1);
        wr(2'd2, 32'd1);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("coal_hold%0d", j), rd_data, 32'd2);
            step();
        end
        chk("coal_reassert", rd_data, 32'd1);

        // Clear lands on the expire edge while in ASSERT.
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd3);
        wait_intr(n);
        repeat (3) step();
        rd_addr = 2'd3;
        #1;
        chk("simul_cnt_zero", rd_data, 32'd0);
        rd_addr = 2'd2;
        wr(2'd2, 32'd1);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("simul_hold%0d", j), rd_data, 32'd2);
            step();
        end
        chk("simul_reassert", rd_data, 32'd1);

        // LOAD write on the expire cycle wins the counter; the interrupt still fires.
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd3);
        repeat (3) step();
        rd_addr = 2'd3;
        wr(2'd1, 32'd10);
        chk("prio_cnt", rd_data, 32'd10);
        chk("prio_intr", {31'd0, intr}, 32'd1);
        step();
        chk("prio_cnt_dec", rd_data, 32'd9);

        // Asynchronous reset while intr=1 and counter=7.
        do_reset();
        wr(2'd1, 32'd8);
        wr(2'd0, 32'd3);
        wait_intr(n);
        step();
        rd_addr = 2'd3;
        #1;
        chk("pre_rst_cnt", rd_data, 32'd7);
        chk("pre_rst_intr", {31'd0, intr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cnt", rd_data, 32'd0);
        chk("rst_intr", {31'd0, intr}, 32'd0);
        rd_addr = 2'd0;
        #1;
        chk("rst_ctrl", rd_data, 32'd0);
        step();
        rst_n = 1'b1;
        hi = 0;
        for (int j = 0; j < 100; j++) begin
            step();
            if (intr) hi++;
        end
        chk("post_rst_quiet", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
